// File: rtl/vga_timing_gen_if.sv
// Raster bus between the VGA timing generator and the screen drawers:
// pixel enable and background colour in, scan position, syncs and colour out.
interface vga_timing_gen_if;
  localparam int unsigned CNT_W = 11;
  localparam int unsigned COL_W = 8;

  logic             pixelEn;
  logic [COL_W-1:0] BG_RGB;
  logic [CNT_W-1:0] pixelX;
  logic [CNT_W-1:0] pixelY;
  logic             hSync;
  logic             vSync;
  logic             blankN;
  logic             startOfFrame;
  logic [COL_W-1:0] red;
  logic [COL_W-1:0] green;
  logic [COL_W-1:0] blue;

  // Timing generator side
  modport master (
    input  pixelEn, BG_RGB,
    output pixelX, pixelY, hSync, vSync, blankN, startOfFrame, red, green, blue
  );

  // Drawer / display side
  modport slave (
    output pixelEn, BG_RGB,
    input  pixelX, pixelY, hSync, vSync, blankN, startOfFrame, red, green, blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator and VGA output stage. Stage 1 scans pixelX/pixelY;
// stage 2 registers syncs, blanking and expanded colour one pixel later so they
// line up with the colour the drawers return for that position.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned COL_W   = 8;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic             sof_q;
  logic             hs_q;
  logic             vs_q;
  logic             blank_n_q;
  logic [COL_W-1:0] red_q;
  logic [COL_W-1:0] green_q;
  logic [COL_W-1:0] blue_q;

  logic             x_last_c;
  logic             y_last_c;
  logic             active_c;
  logic             hs_c;
  logic             vs_c;
  logic [2:0]       r3_c;
  logic [2:0]       g3_c;
  logic [1:0]       b2_c;

  // Decode of the current stage-1 position and colour field split
  always_comb begin
    x_last_c = 1'b0;
    y_last_c = 1'b0;
    active_c = 1'b0;
    hs_c     = ~SYNC_POL;
    vs_c     = ~SYNC_POL;
    r3_c     = vga.BG_RGB[7:5];
    g3_c     = vga.BG_RGB[4:2];
    b2_c     = vga.BG_RGB[1:0];

    x_last_c = (x_q == H_LAST);
    y_last_c = (y_q == V_LAST);
    active_c = (x_q < H_VIS) && (y_q < V_VIS);
    if ((x_q >= HS_START) && (x_q < HS_END)) hs_c = SYNC_POL;
    if ((y_q >= VS_START) && (y_q < VS_END)) vs_c = SYNC_POL;
  end

  // Stage 1 counters, frame pulse and stage 2 output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      sof_q     <= 1'b0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      blank_n_q <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      // Pulse only on the enabled edge that wraps to (0,0), so it stays one clk wide
      sof_q <= vga.pixelEn && x_last_c && y_last_c;
      if (vga.pixelEn) begin
        if (x_last_c) begin
          x_q <= '0;
          y_q <= y_last_c ? '0 : y_q + CNT_W'(1);
        end else begin
          x_q <= x_q + CNT_W'(1);
        end

        hs_q      <= hs_c;
        vs_q      <= vs_c;
        blank_n_q <= active_c;
        if (active_c) begin
          red_q   <= {r3_c, r3_c, r3_c[2:1]};
          green_q <= {g3_c, g3_c, g3_c[2:1]};
          blue_q  <= {b2_c, b2_c, b2_c, b2_c};
        end else begin
          red_q   <= '0;
          green_q <= '0;
          blue_q  <= '0;
        end
      end
    end
  end

  assign vga.pixelX       = x_q;
  assign vga.pixelY       = y_q;
  assign vga.startOfFrame = sof_q;
  assign vga.hSync        = hs_q;
  assign vga.vSync        = vs_q;
  assign vga.blankN       = blank_n_q;
  assign vga.red          = red_q;
  assign vga.green        = green_q;
  assign vga.blue         = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size instance for line timing, colour
// and reset behaviour; a shrunken-raster instance for frame wrap and vSync.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  vga_timing_gen_if if_m ();
  vga_timing_gen_if if_s ();

  vga_timing_gen u_dut (
    .clk   (clk),
    .reset (reset),
    .vga   (if_m.master)
  );

  // 16 x 11 raster: H 8/2/3/3, V 6/1/2/2 -> 176 enables per frame
  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b0)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .vga   (if_s.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"},   32'(if_m.pixelX), 0);
    check({tag, "_y"},   32'(if_m.pixelY), 0);
    check({tag, "_hs"},  32'(if_m.hSync), 1);
    check({tag, "_vs"},  32'(if_m.vSync), 1);
    check({tag, "_bl"},  32'(if_m.blankN), 0);
    check({tag, "_sof"}, 32'(if_m.startOfFrame), 0);
    check({tag, "_r"},   32'(if_m.red), 0);
    check({tag, "_g"},   32'(if_m.green), 0);
    check({tag, "_b"},   32'(if_m.blue), 0);
  endtask

  // Step the full-size instance (pixelEn=1) until it shows position (x,y)
  task automatic step_until(input int x, input int y, input int budget, input string tag);
    int found;
    found = 0;
    if_m.pixelEn = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (32'(if_m.pixelX) == x && 32'(if_m.pixelY) == y) begin
        found = 1;
        break;
      end
      tick();
    end
    check({tag, "_reach"}, found, 1);
  endtask

  initial begin
    int hs_first, hs_last, hs_cnt, bl_cnt, vs_cnt;
    int sof_cnt, sof_first, sof_second, vs_first, vs_last;
    int exp_x, e;

    reset = 1'b1;
    if_m.pixelEn = 1'b1;
    if_m.BG_RGB  = 8'h00;
    if_s.pixelEn = 1'b0;
    if_s.BG_RGB  = 8'h00;

    // Reset held 3 clks with pixelEn high
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b0;

    // One full line: counter run, hSync window, blanking
    hs_first = -1; hs_last = -1; hs_cnt = 0; bl_cnt = 0; vs_cnt = 0;
    for (int n = 1; n <= 800; n++) begin
      tick();
      check("line_x", 32'(if_m.pixelX), n % 800);
      check("line_y", 32'(if_m.pixelY), n / 800);
      if (!if_m.hSync) begin
        if (hs_first < 0) hs_first = n;
        hs_last = n;
        hs_cnt++;
      end
      if (if_m.blankN) bl_cnt++;
      if (!if_m.vSync) vs_cnt++;
    end
    check("hs_first", hs_first, 657);
    check("hs_last",  hs_last, 752);
    check("hs_len",   hs_cnt, 96);
    check("bl_len",   bl_cnt, 640);
    check("vs_line0", vs_cnt, 0);

    // Colour expansion and alignment
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if_m.BG_RGB = 8'h00;
    step_until(5, 5, 5000, "c55");
    if_m.BG_RGB = 8'hE3;
    tick();
    check("c55_r",  32'(if_m.red), 32'h00FF);
    check("c55_g",  32'(if_m.green), 32'h0000);
    check("c55_b",  32'(if_m.blue), 32'h00FF);
    check("c55_bl", 32'(if_m.blankN), 1);
    if_m.BG_RGB = 8'hA9;
    tick();
    check("c65_r",  32'(if_m.red), 32'h00B6);
    check("c65_g",  32'(if_m.green), 32'h0049);
    check("c65_b",  32'(if_m.blue), 32'h0055);
    if_m.BG_RGB = 8'hE3;
    step_until(700, 5, 1000, "c700");
    tick();
    check("c700_r",  32'(if_m.red), 0);
    check("c700_g",  32'(if_m.green), 0);
    check("c700_b",  32'(if_m.blue), 0);
    check("c700_bl", 32'(if_m.blankN), 0);
    check("c700_hs", 32'(if_m.hSync), 0);
    step_until(639, 6, 1000, "c639");
    tick();
    check("c639_bl", 32'(if_m.blankN), 1);
    check("c639_r",  32'(if_m.red), 32'h00FF);
    tick();
    check("c640_bl", 32'(if_m.blankN), 0);
    check("c640_r",  32'(if_m.red), 0);

    // Reset mid-frame with pixelEn low: reset still wins
    step_until(300, 7, 2000, "mid");
    check("mid_pre_bl", 32'(if_m.blankN), 1);
    reset = 1'b1;
    if_m.pixelEn = 1'b0;
    tick();
    check_reset_vals("mid");
    reset = 1'b0;
    if_m.pixelEn = 1'b1;
    tick();
    check("restart_x",   32'(if_m.pixelX), 1);
    check("restart_y",   32'(if_m.pixelY), 0);
    check("restart_sof", 32'(if_m.startOfFrame), 0);
    check("restart_bl",  32'(if_m.blankN), 1);

    // Reset inside hSync with pixelEn high
    step_until(700, 0, 1000, "hsr");
    check("hsr_pre_hs", 32'(if_m.hSync), 0);
    reset = 1'b1;
    tick();
    check_reset_vals("hsr");
    reset = 1'b0;

    // Alternating pixelEn: advance on enabled clks only, outputs hold otherwise
    exp_x = 0;
    for (int k = 0; k < 10; k++) begin
      if_m.pixelEn = ((k % 2) == 0);
      tick();
      if ((k % 2) == 0) exp_x++;
      check("tog_x",  32'(if_m.pixelX), exp_x);
      check("tog_bl", 32'(if_m.blankN), 1);
      check("tog_r",  32'(if_m.red), 32'h00FF);
    end
    if_m.pixelEn = 1'b0;

    // Two frames on the small raster
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    if_s.pixelEn = 1'b1;
    sof_cnt = 0; sof_first = -1; sof_second = -1;
    vs_first = -1; vs_last = -1; vs_cnt = 0;
    for (int n = 1; n <= 360; n++) begin
      tick();
      if (if_s.startOfFrame) begin
        sof_cnt++;
        if (sof_first < 0) sof_first = n;
        else if (sof_second < 0) sof_second = n;
        check("sof_x", 32'(if_s.pixelX), 0);
        check("sof_y", 32'(if_s.pixelY), 0);
      end
      if (!if_s.vSync && n <= 176) begin
        if (vs_first < 0) vs_first = n;
        vs_last = n;
        vs_cnt++;
      end
    end
    check("sof_cnt",   sof_cnt, 2);
    check("sof_first", sof_first, 176);
    check("sof_gap",   sof_second - sof_first, 176);
    check("vs_first",  vs_first, 113);
    check("vs_last",   vs_last, 144);
    check("vs_len",    vs_cnt, 32);

    // Small raster with alternating pixelEn across the frame wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e = 0; sof_cnt = 0; sof_first = -1;
    for (int n = 1; n <= 400; n++) begin
      if_s.pixelEn = ((n % 2) == 1);
      tick();
      if ((n % 2) == 1) e++;
      if (if_s.startOfFrame) begin
        sof_cnt++;
        if (sof_first < 0) sof_first = n;
      end
      check("stog_x", 32'(if_s.pixelX), (e % 176) % 16);
      check("stog_y", 32'(if_s.pixelY), (e % 176) / 16);
    end
    check("stog_sof_cnt",  sof_cnt, 1);
    check("stog_sof_edge", sof_first, 351);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
